// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions: widths, Control opcodes, responder FSM states.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } resp_state_e;

endpackage

// File: rtl/data_memory_responder_data_ram.sv
// Single-port doubleword RAM: synchronous write, registered read with enable, no reset.
module DataRam #(
  parameter int DEPTH = 256,
  parameter int XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rdata_q;

  // Write port and enabled read register; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency ld/sd responder: latches the request, counts down, commits on entry to DONE.
module data_memory_responder #(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] Address,
  input  logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] ReadData,
  output logic            Ready,
  output logic            Fault,
  output logic            Busy
);
  import riscv_pkg::*;

  localparam int AW = $clog2(DEPTH);

  resp_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            rd_q, rd_d, wr_q, wr_d, flt_q, flt_d;
  logic [AW-1:0]   word_q, word_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            ready_q, ready_d, fault_q, fault_d, busy_q, busy_d;
  logic            rvalid_q, rvalid_d;

  logic            req_fault;
  logic            commit;
  logic            ram_we, ram_re;
  logic [XLEN-1:0] ram_rdata;

  // Live-request fault: misaligned, beyond the array, or both ops at once.
  assign req_fault = (Address[2:0] != 3'd0) ||
                     ((Address >> 3) >= XLEN'(DEPTH)) ||
                     (MemRead && MemWrite);

  // Next state, request capture and countdown; commit marks the edge entering DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    flt_d   = flt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          rd_d    = MemRead;
          wr_d    = MemWrite;
          flt_d   = req_fault;
          word_d  = Address[AW+2:3];
          wdata_d = WriteData;
          if (LATENCY == 1) begin
            state_d = DONE;
            cnt_d   = 4'd0;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          commit  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM action uses the _d copies so a single-cycle request commits on its capture edge;
  // reset blocks the commit so an aborted store never lands.
  assign ram_we = commit && wr_d && !flt_d && !rst;
  assign ram_re = commit && rd_d && !flt_d && !rst;

  // Registered handshake outputs, aligned with the state they describe.
  always_comb begin
    ready_d  = (state_d == DONE);
    busy_d   = (state_d != IDLE);
    fault_d  = (state_d == DONE) && flt_d;
    rvalid_d = rvalid_q || ram_re;
  end

  // State, counter, request latches and output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      flt_q    <= 1'b0;
      word_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      flt_q    <= flt_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
    end
  end

  DataRam #(.DEPTH(DEPTH), .XLEN(XLEN)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (word_d),
    .wdata (wdata_d),
    .rdata (ram_rdata)
  );

  // RAM read register has no reset; present zero until the first successful load.
  assign ReadData = rvalid_q ? ram_rdata : '0;
  assign Ready    = ready_q;
  assign Fault    = fault_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: request table on a LATENCY=2 instance, abort and hold sequences.
module tb_data_memory_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        MemRead, MemWrite, Ready, Fault, Busy;
  logic [63:0] Address, WriteData, ReadData;

  logic        r1, w1, rdy1, flt1, bsy1;
  logic [63:0] a1, d1, rd1;

  data_memory_responder #(.XLEN(64), .DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Ready(Ready), .Fault(Fault), .Busy(Busy)
  );

  data_memory_responder #(.XLEN(64), .DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .MemRead(r1), .MemWrite(w1),
    .Address(a1), .WriteData(d1), .ReadData(rd1),
    .Ready(rdy1), .Fault(flt1), .Busy(bsy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_fault;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  // Issue one request from IDLE, wait (bounded) for Ready, check, and return in IDLE.
  task automatic run_req(input logic rd, input logic wr, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic ef, input logic [63:0] ed,
                         input string tag);
    int n;
    bit got;
    n = 0;
    got = 0;
    MemRead = rd; MemWrite = wr; Address = addr; WriteData = wdata;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (Ready) got = 1;
      else chk({tag, " busy_wait"}, Busy, 1);
    end
    chk({tag, " latency"}, n, 2);
    MemRead = 0; MemWrite = 0;
    if (got) begin
      chk({tag, " fault"}, Fault, ef);
      chk({tag, " rdata"}, ReadData, ed);
      chk({tag, " busy_done"}, Busy, 1);
    end
    @(posedge clk); #1;
    chk({tag, " ready_idle"}, Ready, 0);
    chk({tag, " busy_idle"}, Busy, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 1'b0, 64'h0};
    vecs[1]  = '{1'b1, 1'b0, 64'h10,  64'h0,                 1'b0, 64'hDEADBEEF_CAFEF00D};
    vecs[2]  = '{1'b1, 1'b0, 64'h13,  64'h0,                 1'b1, 64'hDEADBEEF_CAFEF00D};
    vecs[3]  = '{1'b0, 1'b1, 64'h0,   64'h11112222_33334444, 1'b0, 64'hDEADBEEF_CAFEF00D};
    vecs[4]  = '{1'b0, 1'b1, 64'h8,   64'h55556666_77778888, 1'b0, 64'hDEADBEEF_CAFEF00D};
    vecs[5]  = '{1'b0, 1'b1, 64'h800, 64'hBADBADBA_DBADBAD0, 1'b1, 64'hDEADBEEF_CAFEF00D};
    vecs[6]  = '{1'b1, 1'b0, 64'h0,   64'h0,                 1'b0, 64'h11112222_33334444};
    vecs[7]  = '{1'b1, 1'b1, 64'h8,   64'hBAD2BAD2_BAD2BAD2, 1'b1, 64'h11112222_33334444};
    vecs[8]  = '{1'b1, 1'b0, 64'h8,   64'h0,                 1'b0, 64'h55556666_77778888};
    vecs[9]  = '{1'b0, 1'b1, 64'h7F8, 64'hA5A5A5A5_5A5A5A5A, 1'b0, 64'h55556666_77778888};
    vecs[10] = '{1'b1, 1'b0, 64'h7F8, 64'h0,                 1'b0, 64'hA5A5A5A5_5A5A5A5A};
    vecs[11] = '{1'b0, 1'b1, 64'h18,  64'h01234567_89ABCDEF, 1'b0, 64'hA5A5A5A5_5A5A5A5A};

    rst = 1'b1;
    MemRead = 0; MemWrite = 0; Address = '0; WriteData = '0;
    r1 = 0; w1 = 0; a1 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", Ready, 0);
    chk("reset fault", Fault, 0);
    chk("reset busy", Busy, 0);
    chk("reset rdata", ReadData, 0);
    chk("reset ready1", rdy1, 0);
    chk("reset busy1", bsy1, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_fault, vecs[i].exp_data, $sformatf("vec%0d", i));

    // Abort a store to 0x18 in its BUSY cycle.
    MemWrite = 1; Address = 64'h18; WriteData = 64'hFFFFFFFF_FFFFFFFF;
    @(posedge clk); #1;
    chk("abort busy", Busy, 1);
    rst = 1'b1;
    #1;
    chk("abort ready", Ready, 0);
    chk("abort fault", Fault, 0);
    chk("abort busy_rst", Busy, 0);
    chk("abort rdata", ReadData, 0);
    MemWrite = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_req(1'b1, 1'b0, 64'h18, 64'h0, 1'b0, 64'h01234567_89ABCDEF, "abort_ld");

    // LATENCY=1: single store, then a held load completing every other cycle.
    w1 = 1; a1 = 64'h0; d1 = 64'h77;
    @(posedge clk); #1;
    chk("hold sd ready", rdy1, 1);
    chk("hold sd fault", flt1, 0);
    w1 = 0;
    @(posedge clk); #1;
    chk("hold sd idle", rdy1, 0);
    r1 = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold ready%0d", i), rdy1, (i % 2 == 0));
      chk($sformatf("hold busy%0d", i), bsy1, (i % 2 == 0));
      if (i % 2 == 0) chk($sformatf("hold rdata%0d", i), rd1, 64'h77);
    end
    r1 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
